// File: rtl/serial_adder.sv
// serial_adder: multi-cycle adder, CHUNK bits per clock; define SERIAL_ADDER_SUB_EN to add the sub port
module serial_adder #(
    parameter int WIDTH = 8,
    parameter int CHUNK = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);
    localparam int N  = WIDTH / CHUNK;
    localparam int CW = $clog2(N + 1);

    if (WIDTH < 1 || CHUNK < 1 || WIDTH % CHUNK != 0) begin : g_bad_cfg
        $error("serial_adder: CHUNK must divide WIDTH");
    end

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t           r_state, w_next;
    logic [WIDTH-1:0] r_a, r_b, r_sh, r_sum, w_sh_next;
    logic [CW-1:0]    r_cnt;
    logic [CHUNK:0]   w_slice;
    logic             r_carry, r_cout, r_ovf, r_in_ready;
    logic             w_sub, w_accept, w_last, w_msb_cin;

`ifdef SERIAL_ADDER_SUB_EN
    assign w_sub = sub;
`else
    assign w_sub = 1'b0;
`endif

    assign w_accept  = in_valid && r_in_ready;
    assign w_last    = r_cnt == CW'(N - 1);
    assign w_slice   = {1'b0, r_a[CHUNK-1:0]} + {1'b0, r_b[CHUNK-1:0]} + (CHUNK+1)'(r_carry);
    assign w_msb_cin = r_a[CHUNK-1] ^ r_b[CHUNK-1] ^ w_slice[CHUNK-1];
    assign w_sh_next = WIDTH'({w_slice[CHUNK-1:0], r_sh} >> CHUNK);

    assign in_ready  = r_in_ready;
    assign out_valid = r_state == DONE;
    assign sum       = r_sum;
    assign cout      = r_cout;
    assign ovf       = r_ovf;

    // next-state: accept in IDLE, run N slices in BUSY, hold result in DONE until taken
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE:    w_next = w_accept  ? BUSY : IDLE;
            BUSY:    w_next = w_last    ? DONE : BUSY;
            DONE:    w_next = out_ready ? IDLE : DONE;
            default: w_next = IDLE;
        endcase
    end

    // state, operand shifters and result registers; subtract is folded in as ~b with carry 1
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_in_ready <= 1'b0;
            r_a        <= '0;
            r_b        <= '0;
            r_sh       <= '0;
            r_carry    <= 1'b0;
            r_cnt      <= '0;
            r_sum      <= '0;
            r_cout     <= 1'b0;
            r_ovf      <= 1'b0;
        end else begin
            r_state    <= w_next;
            r_in_ready <= w_next == IDLE;
            if (r_state == IDLE && w_accept) begin
                r_a     <= a;
                r_b     <= w_sub ? ~b : b;
                r_carry <= w_sub ? 1'b1 : cin;
                r_cnt   <= '0;
            end else if (r_state == BUSY) begin
                r_a     <= r_a >> CHUNK;
                r_b     <= r_b >> CHUNK;
                r_sh    <= w_sh_next;
                r_carry <= w_slice[CHUNK];
                r_cnt   <= r_cnt + CW'(1);
                if (w_last) begin
                    r_sum  <= w_sh_next;
                    r_cout <= w_slice[CHUNK];
                    r_ovf  <= w_msb_cin ^ w_slice[CHUNK];
                end
            end
        end
    end
endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: scoreboard bench for serial_adder (CHUNK=1 and 4; CHUNK=2 subtract with SERIAL_ADDER_SUB_EN)
module tb_serial_adder;
`ifdef SERIAL_ADDER_SUB_EN
    localparam int ND = 3;
`else
    localparam int ND = 2;
`endif

    typedef struct packed {
        logic [7:0] s;
        logic       c;
        logic       o;
        int         acc;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       iv[ND], ir[ND], tcin[ND], tsub[ND], ov[ND], ordy[ND], co[ND], of[ND];
    logic [7:0] ta[ND], tbv[ND], sm[ND];
    exp_t       q[ND][$];
    logic [9:0] prev[ND];
    logic       pov[ND];
    int         cyc = 0;
    int         checks = 0;
    int         errors = 0;

    always #5 clk = ~clk;

    serial_adder #(.WIDTH(8), .CHUNK(1)) u0 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(ir[0]), .a(ta[0]), .b(tbv[0]), .cin(tcin[0]),
`ifdef SERIAL_ADDER_SUB_EN
        .sub(tsub[0]),
`endif
        .out_valid(ov[0]), .out_ready(ordy[0]), .sum(sm[0]), .cout(co[0]), .ovf(of[0]));

    serial_adder #(.WIDTH(8), .CHUNK(4)) u1 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(ir[1]), .a(ta[1]), .b(tbv[1]), .cin(tcin[1]),
`ifdef SERIAL_ADDER_SUB_EN
        .sub(tsub[1]),
`endif
        .out_valid(ov[1]), .out_ready(ordy[1]), .sum(sm[1]), .cout(co[1]), .ovf(of[1]));

`ifdef SERIAL_ADDER_SUB_EN
    serial_adder #(.WIDTH(8), .CHUNK(2)) u2 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .in_ready(ir[2]), .a(ta[2]), .b(tbv[2]), .cin(tcin[2]),
        .sub(tsub[2]),
        .out_valid(ov[2]), .out_ready(ordy[2]), .sum(sm[2]), .cout(co[2]), .ovf(of[2]));
`endif

    function automatic int lat(input int d);
        return d == 0 ? 8 : (d == 1 ? 2 : 4);
    endfunction

    task automatic chk(input string name, input int d, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s dut%0d: got 0x%0h expected 0x%0h", name, d, act, exp);
        end
    endtask

    task automatic issue(input int d, input logic [7:0] ia, input logic [7:0] ib, input logic ic, input logic is,
                         input logic [7:0] es, input logic ec, input logic eo, output int acc);
        int t;
        t = 0;
        acc = 0;
        while (!ir[d] && t < 100) begin
            @(posedge clk); #1;
            t++;
        end
        chk("accept_wait", d, 32'(ir[d]), 32'd1);
        if (!ir[d]) return;
        ta[d]   = ia;
        tbv[d]  = ib;
        tcin[d] = ic;
        tsub[d] = is;
        iv[d]   = 1'b1;
        @(posedge clk); #1;
        acc = cyc;
        q[d].push_back('{s: es, c: ec, o: eo, acc: cyc});
        iv[d]   = 1'b0;
        ta[d]   = 8'($urandom);
        tbv[d]  = 8'($urandom);
        tcin[d] = 1'($urandom);
        tsub[d] = 1'($urandom);
    endtask

    task automatic drain(input int d);
        int t;
        t = 0;
        while (q[d].size() != 0 && t < 200) begin
            @(posedge clk); #1;
            t++;
        end
        chk("drain", d, 32'(q[d].size()), 32'd0);
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial forever begin
        @(negedge clk);
        for (int d = 0; d < ND; d++) begin
            if (!rst_n) begin
                q[d].delete();
                prev[d] = '0;
                pov[d]  = 1'b0;
            end else if (ov[d]) begin
                chk("out_has_op", d, 32'(q[d].size() != 0), 32'd1);
                if (q[d].size() != 0) begin
                    if (!pov[d]) chk("latency", d, 32'(cyc - q[d][0].acc), 32'(lat(d)));
                    chk("result", d, 32'({sm[d], co[d], of[d]}), 32'({q[d][0].s, q[d][0].c, q[d][0].o}));
                    if (ordy[d]) begin
                        prev[d] = {q[d][0].s, q[d][0].c, q[d][0].o};
                        void'(q[d].pop_front());
                    end
                end
                pov[d] = 1'b1;
            end else begin
                chk("hold", d, 32'({sm[d], co[d], of[d]}), 32'(prev[d]));
                pov[d] = 1'b0;
            end
        end
    end

    initial begin
        int a0, a1, a2, t;
        for (int d = 0; d < ND; d++) begin
            iv[d] = 1'b0; ta[d] = '0; tbv[d] = '0; tcin[d] = 1'b0; tsub[d] = 1'b0; ordy[d] = 1'b1;
            prev[d] = '0; pov[d] = 1'b0;
        end
        repeat (2) @(posedge clk);
        #1;
        for (int d = 0; d < ND; d++)
            chk("reset_outputs", d, 32'({ir[d], ov[d], sm[d], co[d], of[d]}), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        for (int d = 0; d < ND; d++)
            chk("in_ready_after_reset", d, 32'(ir[d]), 32'd1);

        issue(0, 8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, a0);
        drain(0);
        issue(0, 8'h7F, 8'h01, 1'b1, 1'b0, 8'h81, 1'b0, 1'b1, a0);
        drain(0);

        ordy[0] = 1'b0;
        issue(0, 8'h10, 8'h20, 1'b0, 1'b0, 8'h30, 1'b0, 1'b0, a0);
        t = 0;
        while (!ov[0] && t < 50) begin
            @(posedge clk); #1;
            t++;
        end
        chk("bp_out_valid", 0, 32'(ov[0]), 32'd1);
        for (int i = 0; i < 5; i++) begin
            iv[0] = 1'b1; ta[0] = 8'hAA; tbv[0] = 8'h55;
            @(posedge clk); #1;
            chk("bp_in_ready", 0, 32'(ir[0]), 32'd0);
            chk("bp_out_valid_hold", 0, 32'(ov[0]), 32'd1);
        end
        iv[0] = 1'b0;
        ordy[0] = 1'b1;
        @(posedge clk); #1;
        chk("release_out_valid", 0, 32'(ov[0]), 32'd0);
        chk("release_in_ready", 0, 32'(ir[0]), 32'd1);
        repeat (3) @(posedge clk);
        #1;

        issue(0, 8'h99, 8'h11, 1'b0, 1'b0, 8'hAA, 1'b0, 1'b0, a0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        chk("midop_reset_outputs", 0, 32'({ir[0], ov[0], sm[0], co[0], of[0]}), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("in_ready_after_midop_reset", 0, 32'(ir[0]), 32'd1);
        issue(0, 8'h12, 8'h34, 1'b0, 1'b0, 8'h46, 1'b0, 1'b0, a0);
        drain(0);

        issue(1, 8'h3C, 8'hC4, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, a0);
        drain(1);
        issue(1, 8'h01, 8'h02, 1'b0, 1'b0, 8'h03, 1'b0, 1'b0, a0);
        issue(1, 8'h70, 8'h10, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1, a1);
        issue(1, 8'hF0, 8'h0F, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, a2);
        chk("initiation_interval_1", 1, 32'(a1 - a0), 32'd4);
        chk("initiation_interval_2", 1, 32'(a2 - a1), 32'd4);
        drain(1);

`ifdef SERIAL_ADDER_SUB_EN
        issue(2, 8'h05, 8'h07, 1'b0, 1'b1, 8'hFE, 1'b0, 1'b0, a0);
        drain(2);
        issue(2, 8'h80, 8'h01, 1'b1, 1'b1, 8'h7F, 1'b1, 1'b1, a0);
        drain(2);
        issue(2, 8'h05, 8'h07, 1'b1, 1'b0, 8'h0D, 1'b0, 1'b0, a0);
        drain(2);
`endif

        repeat (4) @(posedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/serial_adder.md
# serial_adder

Parametrised multi-cycle adder. It accepts two WIDTH-bit operands over a valid/ready handshake and adds them CHUNK bits per clock using a single CHUNK-bit full-adder slice and a registered carry. It returns sum, carry-out and signed overflow over a second valid/ready handshake. It is the sequential, width-generic successor to the single-bit full-adder cell, for datapaths that trade latency for area.

## Interface
- WIDTH, default 8: operand/sum width in bits; must be ≥ 1.
- CHUNK, default 1: bits added per cycle; must divide WIDTH (elaboration error otherwise).
- clk  input  1  rising-edge clock; the only clock.
- rst_n  input  1  reset, synchronous, active-low.
- in_valid  input  1  operands present.
- in_ready  output  1  block can accept operands.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- cin  input  1  carry-in.
- sub  input  1  subtract select; present only with SERIAL_ADDER_SUB_EN.
- out_valid  output  1  result present.
- out_ready  input  1  consumer takes result.
- sum  output  WIDTH  result.
- cout  output  1  carry-out of MSB (not-borrow in subtract).
- ovf  output  1  signed overflow: carry into MSB XOR carry out of MSB.

## Operation
- Define N = WIDTH/CHUNK. The counter is $clog2(N+1) bits wide.
- States: IDLE, BUSY, DONE. Reset state is IDLE.
- IDLE:
  - in_ready=1, out_valid=0.
  - On in_valid&&in_ready: latch a, b, cin into shift registers, clear the counter, go to BUSY.
- BUSY:
  - in_ready=0.
  - Each cycle: add the low CHUNK bits of the A and B shift registers plus the carry register.
  - Shift the CHUNK result bits into the MSB end of the result shift register, shift A and B right by CHUNK, update the carry, and increment the counter.
  - On the cycle the counter reaches N-1, also latch sum, cout and ovf into the output registers and go to DONE.
- DONE:
  - out_valid=1; sum, cout and ovf are stable.
  - On out_ready, go to IDLE.
  - in_valid is ignored.
- Output registers sum, cout and ovf hold the last completed result at all times. They change only on the BUSY→DONE edge and never show partial values.
- in_valid is ignored in BUSY and DONE. Operand inputs are sampled only on the accept edge and may change freely afterwards.
- Addition is modulo 2^WIDTH. cout is bit WIDTH of a+b+cin.

## Timing
- Reset (rst_n=0 at a rising edge):
  - state=IDLE.
  - in_ready=0, out_valid=0, sum=0, cout=0, ovf=0.
  - Internal shift registers, carry and counter are cleared.
- in_ready is registered. It goes to 1 on the first edge with rst_n=1.
- Reset mid-BUSY or mid-DONE aborts the operation. No result is produced, and outputs take their reset values on that edge.
- Latency: with the accept on edge E0, out_valid=1 after edge E_N (N cycles).
- If out_ready=1 when out_valid rises, the result transfers on edge E_{N+1}. in_ready=1 after E_{N+1}, and the earliest next accept is E_{N+2}.
- Minimum initiation interval is N+2 cycles.
- Back-pressure: out_valid and the outputs hold indefinitely while out_ready=0.
- WIDTH=CHUNK (N=1) is legal: one BUSY cycle.

## Configuration
- Macro: SERIAL_ADDER_SUB_EN.
- Defined:
  - The sub port exists and is latched with the operands.
  - With sub=1, the block computes a−b as a+~b+1: cin is ignored, and cout=1 means no borrow. ovf uses the same MSB-carry rule.
  - With sub=0, behaviour is identical to the undefined build.
- Undefined: no sub port; the block adds only.

## Test plan
- WIDTH=8, CHUNK=1; a=0xFF, b=0x01, cin=0 → sum=0x00, cout=1, ovf=0; out_valid rises exactly 8 cycles after the accept edge.
- WIDTH=8, CHUNK=1; a=0x7F, b=0x01, cin=1 → sum=0x81, cout=0, ovf=1; sum/cout/ovf remain at the previous result values until out_valid rises.
- Back-pressure: hold out_ready=0 for 5 cycles after out_valid while pulsing in_valid with new operands → out_valid, sum and cout stable throughout, in_ready=0, new operands not accepted; out_ready=1 → IDLE on the next edge.
- Reset mid-operation: assert rst_n=0 during the 3rd BUSY cycle → all outputs 0 on that edge; after release, in_ready=1 on the next edge; a=0x12, b=0x34 → sum=0x46, cout=0.
- WIDTH=8, CHUNK=4; a=0x3C, b=0xC4, cin=0 → sum=0x00, cout=1, ovf=0, latency 2 cycles; back-to-back ops with out_ready tied high accepted every 4 cycles.
- SERIAL_ADDER_SUB_EN defined, WIDTH=8, CHUNK=2:
  - a=0x05, b=0x07, sub=1, cin=0 → sum=0xFE, cout=0, ovf=0.
  - a=0x80, b=0x01, sub=1 → sum=0x7F, cout=1, ovf=1.
